// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan monitor and other display checkers.
//   - Segment patterns (bit0=a .. bit6=g) for decimal digits 0-9 and blank.
//   - 4-bit codes reported for blank and undecodable patterns.
//   - Capture FSM state type.
//   - enable_index(): position of the low bit in an active-low enable bus.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } scan_state_e;

    // Lowest-numbered low bit; only meaningful when exactly one bit is low.
    function automatic logic [2:0] enable_index(input logic [7:0] en_n);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!en_n[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Display-side bundle of the scan monitor.
//   seg_en      : digit enables, active-low (bit i low selects digit i)
//   seg_data    : segments, active-high (bit0=a .. bit6=g, bit7=dp)
//   digit_codes : snapshot, nibble i = code of digit i
//   digit_dp    : snapshot decimal points
//   frame_done  : one-cycle pulse when the snapshot updates
//   err_multi   : one-cycle pulse per sample with more than one enable low
//   scan_stall  : level, no capture for the configured stall period
// master = the side driving the display bus (board or bench); slave = the monitor.
interface seg_scan_capture_if;

    logic [7:0]  seg_en;
    logic [7:0]  seg_data;
    logic [31:0] digit_codes;
    logic [7:0]  digit_dp;
    logic        frame_done;
    logic        err_multi;
    logic        scan_stall;

    modport master (
        output seg_en,
        output seg_data,
        input  digit_codes,
        input  digit_dp,
        input  frame_done,
        input  err_multi,
        input  scan_stall
    );

    modport slave (
        input  seg_en,
        input  seg_data,
        output digit_codes,
        output digit_dp,
        output frame_done,
        output err_multi,
        output scan_stall
    );

endinterface

// File: rtl/seg_scan_capture_seg7_decode.sv
// Combinational seven-segment pattern decoder.
//   pattern_i : segments a..g (bit0=a), active-high
//   code_o    : 0-9 for digit patterns, CODE_BLANK for all-off, CODE_INVALID otherwise
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o
);

    always_comb begin
        code_o = CODE_INVALID;
        case (pattern_i)
            SEG_0:     code_o = 4'd0;
            SEG_1:     code_o = 4'd1;
            SEG_2:     code_o = 4'd2;
            SEG_3:     code_o = 4'd3;
            SEG_4:     code_o = 4'd4;
            SEG_5:     code_o = 4'd5;
            SEG_6:     code_o = 4'd6;
            SEG_7:     code_o = 4'd7;
            SEG_8:     code_o = 4'd8;
            SEG_9:     code_o = 4'd9;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   code_o = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Monitor for a multiplexed 8-digit seven-segment display.
// Registers the scanned enable/segment buses, waits for each digit to hold steady for
// SETTLE_CYC samples, decodes it into a working buffer and publishes the buffer as a
// snapshot once all eight digits have been captured.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seg_scan_capture_if (display inputs, snapshot/status outputs)
// Parameters:
//   SETTLE_CYC : identical consecutive samples needed before capture (1-255)
//   STALL_CYC  : capture-free cycles before scan_stall asserts
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned STALL_CYC  = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_capture_if.slave bus
);

    localparam int unsigned        StallW     = $clog2(STALL_CYC + 1);
    localparam logic [StallW-1:0]  StallMax   = StallW'(STALL_CYC);
    localparam logic [7:0]         SettleLast = 8'(SETTLE_CYC);

    // Input stage and one-sample history.
    logic [7:0] en_q, en_d;
    logic [7:0] data_q, data_d;
    logic [7:0] last_en_q, last_en_d;
    logic [7:0] last_data_q, last_data_d;

    // Capture FSM.
    scan_state_e state_q, state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;

    // Working buffer and published snapshot.
    logic [31:0] wcodes_q, wcodes_d;
    logic [7:0]  wdp_q, wdp_d;
    logic [7:0]  seen_q, seen_d;
    logic [31:0] digit_codes_q, digit_codes_d;
    logic [7:0]  digit_dp_q, digit_dp_d;
    logic        frame_done_q, frame_done_d;
    logic        err_multi_q, err_multi_d;
    logic [StallW-1:0] stall_cnt_q, stall_cnt_d;

    // Sample classification.
    logic [7:0] en_low;
    logic       sample_valid;
    logic       sample_multi;
    logic       sample_same;
    logic [2:0] sample_idx;
    logic [3:0] dec_code;

    logic       capture;
    logic       restart;
    logic       frame_hit;

    seg7_decode u_decode (
        .pattern_i (data_q[6:0]),
        .code_o    (dec_code)
    );

    always_comb begin
        en_d        = bus.seg_en;
        data_d      = bus.seg_data;
        last_en_d   = en_q;
        last_data_d = data_q;
    end

    always_comb begin
        en_low       = ~en_q;
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
        sample_valid = (en_low != 8'd0) && ((en_low & (en_low - 8'd1)) == 8'd0);
        sample_multi = (en_low != 8'd0) && !sample_valid;
        sample_same  = (en_q == last_en_q) && (data_q == last_data_q);
        sample_idx   = enable_index(en_q);
    end

    // Settle/capture state machine.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        capture      = 1'b0;
        restart      = 1'b0;

        case (state_q)
            SETTLE: begin
                if (sample_same) begin
                    if (settle_cnt_q + 8'd1 >= SettleLast) begin
                        capture = 1'b1;
                        state_d = HELD;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end else begin
                    restart = 1'b1;
                end
            end
            HELD: begin
                // A digit is captured once per stable run; only a change re-arms it.
                if (!sample_same) begin
                    restart = 1'b1;
                end
            end
            default: begin
                restart = 1'b1;
            end
        endcase

        if (restart) begin
            if (sample_valid) begin
                settle_cnt_d = 8'd1;
                if (SettleLast <= 8'd1) begin
                    capture = 1'b1;
                    state_d = HELD;
                end else begin
                    state_d = SETTLE;
                end
            end else begin
                settle_cnt_d = 8'd0;
                state_d      = IDLE;
            end
        end
    end

    // Working buffer, frame publication and status.
    always_comb begin
        wcodes_d      = wcodes_q;
        wdp_d         = wdp_q;
        frame_hit     = (seen_q == 8'hFF);
        // A full mask is published and cleared on the following edge, so the copy
        // includes the completing capture and a new frame can start on that same edge.
        seen_d        = frame_hit ? 8'h00 : seen_q;
        frame_done_d  = frame_hit;
        digit_codes_d = frame_hit ? wcodes_q : digit_codes_q;
        digit_dp_d    = frame_hit ? wdp_q : digit_dp_q;
        err_multi_d   = sample_multi;

        if (capture) begin
            wcodes_d[{sample_idx, 2'b00} +: 4] = dec_code;
            wdp_d[sample_idx]                  = data_q[7];
            seen_d[sample_idx]                 = 1'b1;
        end

        if (capture) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q == StallMax) begin
            stall_cnt_d = stall_cnt_q;
        end else begin
            stall_cnt_d = stall_cnt_q + StallW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q          <= 8'hFF;
            data_q        <= 8'h00;
            last_en_q     <= 8'hFF;
            last_data_q   <= 8'h00;
            state_q       <= IDLE;
            settle_cnt_q  <= 8'd0;
            wcodes_q      <= 32'hFFFF_FFFF;
            wdp_q         <= 8'h00;
            seen_q        <= 8'h00;
            digit_codes_q <= 32'hFFFF_FFFF;
            digit_dp_q    <= 8'h00;
            frame_done_q  <= 1'b0;
            err_multi_q   <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            en_q          <= en_d;
            data_q        <= data_d;
            last_en_q     <= last_en_d;
            last_data_q   <= last_data_d;
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            wcodes_q      <= wcodes_d;
            wdp_q         <= wdp_d;
            seen_q        <= seen_d;
            digit_codes_q <= digit_codes_d;
            digit_dp_q    <= digit_dp_d;
            frame_done_q  <= frame_done_d;
            err_multi_q   <= err_multi_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.digit_codes = digit_codes_q;
    assign bus.digit_dp    = digit_dp_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err_multi   = err_multi_q;
    assign bus.scan_stall  = (stall_cnt_q == StallMax);

endmodule
